// File: rtl/block_mover.sv
// block_mover: owns the falling block's position on the ROWS x COLS playfield.
// It handles spawn, user left/right/down moves through a ready/valid handshake,
// and gravity steps. It also detects landing and game over. Every output is a register.
module block_mover #(
    parameter int ROWS      = 16,
    parameter int COLS      = 10,
    parameter int SPAWN_COL = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [ROWS*COLS-1:0]      screen_i,
    input  logic                      spawn_i,
    input  logic                      grav_tick_i,
    input  logic                      move_valid_i,
    input  logic [1:0]                move_dir_i,
    output logic                      move_ready_o,
    output logic [$clog2(COLS)-1:0]   hor_block_o,
    output logic [$clog2(ROWS)-1:0]   vert_block_o,
    output logic                      active_o,
    output logic                      move_done_o,
    output logic                      moved_o,
    output logic                      landed_o,
    output logic                      game_over_o
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_ACTIVE,
        S_CHECK,
        S_LAND
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   hor_q, hor_d;
    logic [RW-1:0]   vert_q, vert_d;
    logic [1:0]      dir_q, dir_d;
    logic            grav_pend_q, grav_pend_d;
    logic            active_q, active_d;
    logic            move_ready_q, move_ready_d;
    logic            move_done_q, move_done_d;
    logic            moved_q, moved_d;
    logic            landed_q, landed_d;
    logic            game_over_q, game_over_d;

    // Result of testing the latched direction against the board in CHECK.
    logic            blocked;
    logic [CW-1:0]   hor_tgt;
    logic [RW-1:0]   vert_tgt;
    logic            spawn_cell_full;

    // A cell outside the playfield is treated as filled. Callers test the
    // boundary first, so this is only a guard against out-of-range indexing.
    function automatic logic cell_filled(input logic [N-1:0] scr,
                                         input int r, input int c);
        int idx;
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
            return 1'b1;
        end
        idx = r * COLS + c;
        return scr[idx[IW-1:0]];
    endfunction

    assign spawn_cell_full = cell_filled(screen_i, 0, SPAWN_COL);

    // Evaluate the latched move against the current screen: blocked flag and target cell.
    always_comb begin
        blocked  = 1'b1;
        hor_tgt  = hor_q;
        vert_tgt = vert_q;
        case (dir_q)
            DIR_LEFT: begin
                if (hor_q != '0) begin
                    if (!cell_filled(screen_i, int'(vert_q), int'(hor_q) - 1)) begin
                        blocked = 1'b0;
                        hor_tgt = hor_q - CW'(1);
                    end
                end
            end
            DIR_RIGHT: begin
                if (hor_q != CW'(COLS - 1)) begin
                    if (!cell_filled(screen_i, int'(vert_q), int'(hor_q) + 1)) begin
                        blocked = 1'b0;
                        hor_tgt = hor_q + CW'(1);
                    end
                end
            end
            DIR_DOWN: begin
                if (vert_q != RW'(ROWS - 1)) begin
                    if (!cell_filled(screen_i, int'(vert_q) + 1, int'(hor_q))) begin
                        blocked  = 1'b0;
                        vert_tgt = vert_q + RW'(1);
                    end
                end
            end
            default: begin
                blocked = 1'b1;
            end
        endcase
    end

    // Next-state and registered-output logic for the movement FSM.
    always_comb begin
        state_d      = state_q;
        hor_d        = hor_q;
        vert_d       = vert_q;
        dir_d        = dir_q;
        grav_pend_d  = grav_pend_q;
        active_d     = active_q;
        move_done_d  = 1'b0;
        moved_d      = 1'b0;
        landed_d     = 1'b0;
        game_over_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (spawn_i) begin
                    state_d = S_SPAWN;
                end
            end

            S_SPAWN: begin
                if (spawn_cell_full) begin
                    game_over_d = 1'b1;
                    active_d    = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    hor_d    = CW'(SPAWN_COL);
                    vert_d   = '0;
                    active_d = 1'b1;
                    state_d  = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                if (move_valid_i && move_ready_q) begin
                    // A user move takes priority; a coincident tick is deferred.
                    dir_d   = move_dir_i;
                    state_d = S_CHECK;
                    if (grav_tick_i) begin
                        grav_pend_d = 1'b1;
                    end
                end else if (grav_pend_q || grav_tick_i) begin
                    dir_d       = DIR_DOWN;
                    grav_pend_d = 1'b0;
                    state_d     = S_CHECK;
                end
            end

            S_CHECK: begin
                if (grav_tick_i) begin
                    grav_pend_d = 1'b1;
                end
                move_done_d = 1'b1;
                moved_d     = !blocked;
                hor_d       = hor_tgt;
                vert_d      = vert_tgt;
                if (blocked && dir_q == DIR_DOWN) begin
                    state_d = S_LAND;
                end else begin
                    state_d = S_ACTIVE;
                end
            end

            S_LAND: begin
                // Position is held so the commit logic can write the resting cell.
                landed_d    = 1'b1;
                active_d    = 1'b0;
                grav_pend_d = 1'b0;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        move_ready_d = (state_d == S_ACTIVE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            hor_q        <= CW'(SPAWN_COL);
            vert_q       <= '0;
            dir_q        <= DIR_LEFT;
            grav_pend_q  <= 1'b0;
            active_q     <= 1'b0;
            move_ready_q <= 1'b0;
            move_done_q  <= 1'b0;
            moved_q      <= 1'b0;
            landed_q     <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hor_q        <= hor_d;
            vert_q       <= vert_d;
            dir_q        <= dir_d;
            grav_pend_q  <= grav_pend_d;
            active_q     <= active_d;
            move_ready_q <= move_ready_d;
            move_done_q  <= move_done_d;
            moved_q      <= moved_d;
            landed_q     <= landed_d;
            game_over_q  <= game_over_d;
        end
    end

    assign move_ready_o = move_ready_q;
    assign hor_block_o  = hor_q;
    assign vert_block_o = vert_q;
    assign active_o     = active_q;
    assign move_done_o  = move_done_q;
    assign moved_o      = moved_q;
    assign landed_o     = landed_q;
    assign game_over_o  = game_over_q;

endmodule
